// File: rtl/gmul_seq_ctrl.sv
// gmul_seq_ctrl: sequencing controller for a wide GF(2^DWIDTH) multiply,
// p = a*b mod (x^DWIDTH + m). Operand b is consumed one byte per cycle,
// LSB byte first. Each cycle an 8-bit-b slice (gmul_primitive) forms
// a_cur*b_byte, and a_cur is advanced by x^8. Latency is fixed at NCHUNK
// RUN cycles, independent of operand values.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   abort                 synchronous flush; clears all operand/result state
//   in_valid/in_ready     request handshake; in_a, in_b, in_m sampled on accept
//   out_valid/out_ready   response handshake; out_p holds the product
//   busy                  high while a request is in RUN or DONE

// gmul_primitive: combinational slice, p_o = a_i * b_i (b_i 8 bits) mod poly,
// and a_x8_o = a_i * x^8 mod poly for the next byte position.
module gmul_primitive #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [7:0]   b_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] p_o,
  output logic [W-1:0] a_x8_o
);
  logic [W-1:0] v;
  logic [W-1:0] p;

  always_comb begin
    v = a_i;
    p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b_i[i]) p = p ^ v;
      v = {v[W-2:0], 1'b0} ^ (m_i & {W{v[W-1]}});
    end
    p_o    = p;
    a_x8_o = v;
  end
endmodule

module gmul_seq_ctrl #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic [DWIDTH-1:0] in_m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_p,
  output logic              busy
);
  localparam int unsigned NCHUNK = DWIDTH / 8;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if ((DWIDTH < 8) || ((DWIDTH % 8) != 0)) begin : g_bad_width
      $error("gmul_seq_ctrl: DWIDTH must be a multiple of 8 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] a_cur_q, a_cur_d;
  logic [DWIDTH-1:0] b_sh_q,  b_sh_d;
  logic [DWIDTH-1:0] m_q,     m_d;
  logic [DWIDTH-1:0] acc_q,   acc_d;
  logic [DWIDTH-1:0] p_q,     p_d;
  logic [CW-1:0]     cnt_q,   cnt_d;

  logic [DWIDTH-1:0] slice_p;
  logic [DWIDTH-1:0] slice_ax8;
  logic [DWIDTH-1:0] acc_next;

  gmul_primitive #(.W(DWIDTH)) u_slice (
    .a_i    (a_cur_q),
    .b_i    (b_sh_q[7:0]),
    .m_i    (m_q),
    .p_o    (slice_p),
    .a_x8_o (slice_ax8)
  );

  assign acc_next = acc_q ^ slice_p;

  always_comb begin
    state_d = state_q;
    a_cur_d = a_cur_q;
    b_sh_d  = b_sh_q;
    m_d     = m_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;

    if (abort) begin
      // Scrub every operand and result register, not just the state.
      state_d = S_IDLE;
      a_cur_d = '0;
      b_sh_d  = '0;
      m_d     = '0;
      acc_d   = '0;
      p_d     = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_cur_d = in_a;
            b_sh_d  = in_b;
            m_d     = in_m;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          acc_d   = acc_next;
          a_cur_d = slice_ax8;
          b_sh_d  = b_sh_q >> 8;
          if (cnt_q == LAST) begin
            // Result includes this cycle's slice; cnt holds at LAST.
            p_d     = acc_next;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_cur_q <= '0;
      b_sh_q  <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_cur_q <= a_cur_d;
      b_sh_q  <= b_sh_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_p     = p_q;
endmodule

// File: doc/gmul_seq_ctrl.md
Name: gmul_seq_ctrl

Overview:
- Sequencing controller for wide GF(2^DWIDTH) multiplication: p = a·b mod (x^DWIDTH + m).
- Operand b is consumed one byte per cycle, LSB byte first. Each cycle one internal 8-bit-b GF multiply slice (gmul_primitive) computes a_cur·b_byte; a_cur is then advanced by x^8.
- Sits between the crypto/auth datapath (GHASH-style MAC for secure debug) and the shared GF multiplier slice. Provides a valid/ready request/response interface with fixed, data-independent latency.

Parameters:
- DWIDTH, 32, field width in bits; must be a multiple of 8 and >= 8; elaboration error otherwise.
- NCHUNK, DWIDTH/8, number of b bytes (derived, localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous abort/flush, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_a  in  DWIDTH  multiplicand.
- in_b  in  DWIDTH  multiplier.
- in_m  in  DWIDTH  reduction polynomial low terms; x^DWIDTH is implicit.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_p  out  DWIDTH  product.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - out_p = 0; all operand, accumulator and count registers = 0.
- States: IDLE, RUN, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - busy = (state != IDLE).
- IDLE: on in_valid && in_ready:
  - a_cur <= in_a; b_sh <= in_b; m_r <= in_m; acc <= 0; cnt <= 0.
  - Go to RUN.
- RUN, each cycle:
  - acc <= acc ^ gmul(a_cur, b_sh[7:0], m_r).
  - a_cur <= a_cur·x^8 mod poly: 8 chained mul2 steps, mul2(v) = {v[DWIDTH-2:0],0} ^ (m_r & {DWIDTH{v[DWIDTH-1]}}).
  - b_sh <= b_sh >> 8; cnt <= cnt + 1.
  - When cnt == NCHUNK-1: out_p <= final acc value (same-edge XOR included); go to DONE.
- Latency:
  - Exactly NCHUNK RUN cycles, regardless of operand values. No early exit on zero bytes; constant-time is mandatory.
  - out_valid rises NCHUNK cycles after the accepting edge.
  - DWIDTH=8: one RUN cycle, out_valid the cycle after next.
- DONE:
  - out_p holds stable while out_valid && !out_ready.
  - On out_ready: go to IDLE; out_p keeps its value (don't-care when out_valid = 0).
  - No new request is accepted in the same cycle; minimum issue interval is NCHUNK + 2 cycles.
- Inputs in_a/in_b/in_m are sampled only at acceptance; later changes have no effect.
- abort (synchronous, any state):
  - Next state IDLE; out_valid drops next cycle.
  - a_cur, b_sh, m_r, acc, cnt and out_p cleared to 0 (key/data scrub).
  - abort has priority over acceptance and over out_ready; an in_valid in the abort cycle is not accepted.
- rst_n asserted mid-RUN or mid-DONE: immediate return to reset values, no output produced.
- cnt width is clog2(NCHUNK), minimum 1 bit; it never wraps past NCHUNK-1.

Test Plan:
- DWIDTH=8, m=0x1B, a=0x57, b=0x83 -> out_p=0xC1, out_valid exactly 1 cycle after acceptance edge +1 (NCHUNK=1); in_ready low until out_ready.
- DWIDTH=32, m=0x0000008D:
  - a=0x00000001, b=0xDEADBEEF -> out_p=0xDEADBEEF, out_valid 4 cycles after acceptance.
  - a=0x00000002, b=0x80000000 -> out_p=0x0000008D (x^32 reduction).
- DWIDTH=32, a=0, b=0xFFFFFFFF, and separately a=0x12345678, b=0 -> out_p=0; latency still 4 cycles (constant-time check).
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_p stable, in_ready=0, in_valid requests ignored; then out_ready=1 -> IDLE next cycle, next request accepted.
- Abort:
  - Assert abort in RUN cycle 2 of 4 -> IDLE next cycle, out_valid never asserts, internal regs and out_p read 0.
  - Assert abort in DONE with out_ready=1 -> out_p cleared.
- Assert rst_n low asynchronously mid-RUN (between clock edges) -> all outputs at reset values immediately; after release, a fresh request completes correctly (random a/b/m vs. reference model, 1000 iterations, DWIDTH=8 and 32).
